// File: rtl/output_deskew_buffer_if.sv
// Signal bundle between the systolic array bottom edge, the deskew buffer and the output writer.
// master = array/writer side, slave = deskew buffer.
interface output_deskew_buffer_if #(
   parameter int SYS_COLS     = 4,
   parameter int ACC_BITWIDTH = 32,
   parameter int DEPTH        = 16,
   parameter int CNT_W        = 16
);
   localparam int FILL_W = $clog2(DEPTH) + 1;

   logic [SYS_COLS-1:0]                   i_valid;
   logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0] i_data;
   logic                                  start;
   logic [CNT_W-1:0]                      num_rows;
   logic                                  o_valid;
   logic                                  o_ready;
   logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0] o_data;
   logic                                  busy;
   logic                                  tile_done;
   logic [FILL_W-1:0]                     fill;
   logic                                  skew_err;
   logic                                  ovf_err;

   modport master (
      output i_valid, i_data, start, num_rows, o_ready,
      input  o_valid, o_data, busy, tile_done, fill, skew_err, ovf_err
   );

   modport slave (
      input  i_valid, i_data, start, num_rows, o_ready,
      output o_valid, o_data, busy, tile_done, fill, skew_err, ovf_err
   );
endinterface

// File: rtl/output_deskew_buffer.sv
// Re-aligns skewed column results into rows, queues them in a FWFT row FIFO (write SYS_COLS-1 cycles
// after column 0, o_valid one cycle later); rows arriving with the FIFO full and no pop are dropped.
module output_deskew_buffer #(
   parameter int SYS_COLS     = 4,
   parameter int ACC_BITWIDTH = 32,
   parameter int DEPTH        = 16,
   parameter int CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst,
   output_deskew_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

   typedef logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0] row_t;
   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   logic [SYS_COLS-1:0] a_vld;
   row_t                a_dat;
   logic                a_v;

   // Column j lags column 0 by j cycles, so it needs SYS_COLS-1-j stages to line up with the last column.
   for (genvar j = 0; j < SYS_COLS; j++) begin : g_col
      localparam int D = SYS_COLS - 1 - j;
      if (D == 0) begin : g_direct
         assign a_vld[j] = bus.i_valid[j];
         assign a_dat[j] = bus.i_data[j];
      end else begin : g_chain
         logic [D-1:0]            v_q;
         logic [ACC_BITWIDTH-1:0] d_q [D];
         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= '0;
               for (int k = 0; k < D; k++) d_q[k] <= '0;
            end else begin
               v_q[0] <= bus.i_valid[j];
               d_q[0] <= bus.i_data[j];
               for (int k = 1; k < D; k++) begin
                  v_q[k] <= v_q[k-1];
                  d_q[k] <= d_q[k-1];
               end
            end
         end
         assign a_vld[j] = v_q[D-1];
         assign a_dat[j] = d_q[D-1];
      end
   end

   assign a_v = a_vld[SYS_COLS-1];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] nrows_q, nrows_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             done_q, done_d;
   logic             collect;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             skew_q, skew_d;
   logic             ovf_q, ovf_d;
   row_t             mem_q [DEPTH];

   logic full, not_empty, pop, push, drop;

   assign full      = (fill_q == FULL_CNT);
   assign not_empty = (fill_q != '0);
   assign pop       = not_empty & bus.o_ready;
   assign push      = a_v & collect & (~full | pop);
   // Dropped rows still count toward the tile so a stalled consumer cannot wedge the FSM.
   assign drop      = a_v & (~collect | (full & ~pop));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         nrows_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nrows_q <= nrows_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      nrows_d = nrows_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      cnt_inc = cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               nrows_d = bus.num_rows;
               cnt_d   = '0;
               if (bus.num_rows == '0) done_d = 1'b1;
               else                    state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (a_v) begin
               cnt_d = cnt_inc;
               if (cnt_inc == nrows_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      collect       = (state_q == S_COLLECT);
      bus.busy      = collect;
      bus.tile_done = done_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      skew_d   = skew_q | (a_vld != {SYS_COLS{a_v}});
      ovf_d    = ovf_q | drop;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   fill_d = fill_q + FW'(1);
         2'b01:   fill_d = fill_q - FW'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         skew_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         skew_q   <= skew_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= a_dat;
   end

   assign bus.o_valid  = not_empty;
   assign bus.o_data   = not_empty ? mem_q[rd_ptr_q] : '0;
   assign bus.fill     = fill_q;
   assign bus.skew_err = skew_q;
   assign bus.ovf_err  = ovf_q;
endmodule

// File: tb/tb_output_deskew_buffer.sv
// Directed + randomized bench for output_deskew_buffer; a queue-based row model predicts every output each cycle.
module tb_output_deskew_buffer;
   localparam int N     = 4;
   localparam int W     = 32;
   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
   localparam int RW    = N * W;

   typedef logic [N-1:0][W-1:0] row_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_deskew_buffer_if #(.SYS_COLS(N), .ACC_BITWIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   output_deskew_buffer #(.SYS_COLS(N), .ACC_BITWIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [N-1:0] sv [int];
   row_t         sd [int];
   row_t         q [$];
   int           cyc, last_rst, checks, errors, done_seen;
   logic         st, rs, rdy, rand_rdy;
   logic [CNT_W-1:0] nr;
   logic         m_busy, m_done, m_skew, m_ovf;
   int           m_cnt, m_nr;

   function automatic row_t rand_row();
      row_t r;
      for (int j = 0; j < N; j++) r[j] = $urandom();
      return r;
   endfunction

   function automatic row_t mk_row(input int base);
      row_t r;
      for (int j = 0; j < N; j++) r[j] = W'(base + j);
      return r;
   endfunction

   function automatic logic [N-1:0] getv(input int c);
      return sv.exists(c) ? sv[c] : '0;
   endfunction

   function automatic row_t getd(input int c);
      return sd.exists(c) ? sd[c] : '0;
   endfunction

   // Column j of a row starting in cycle s is valid in cycle s+j (one later for the late column).
   task automatic sched_row(input int s, input row_t vals, input int late);
      int c;
      for (int j = 0; j < N; j++) begin
         c = s + j + ((j == late) ? 1 : 0);
         if (!sd.exists(c)) sd[c] = rand_row();
         if (!sv.exists(c)) sv[c] = '0;
         sv[c][j] = 1'b1;
         sd[c][j] = vals[j];
      end
   endtask

   task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_step();
      logic [N-1:0] avec, vt;
      row_t r, dt;
      logic av, pop, full, push_ok, done_n;
      int d;
      if (rs) begin
         q.delete();
         m_busy = 1'b0; m_done = 1'b0; m_skew = 1'b0; m_ovf = 1'b0;
         m_cnt = 0; m_nr = 0;
         last_rst = cyc;
         return;
      end
      for (int j = 0; j < N; j++) begin
         d = N - 1 - j;
         if (d == 0 || cyc - d > last_rst) begin
            vt = getv(cyc - d);
            dt = getd(cyc - d);
            avec[j] = vt[j];
            r[j]    = dt[j];
         end else begin
            avec[j] = 1'b0;
            r[j]    = '0;
         end
      end
      av = avec[N-1];
      if (avec != {N{av}}) m_skew = 1'b1;
      done_n  = 1'b0;
      push_ok = 1'b0;
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == DEPTH);
      if (!m_busy) begin
         if (av) m_ovf = 1'b1;
         if (st) begin
            m_nr  = int'(nr);
            m_cnt = 0;
            if (nr == '0) done_n = 1'b1;
            else          m_busy = 1'b1;
         end
      end else if (av) begin
         if (!full || pop) push_ok = 1'b1;
         else              m_ovf = 1'b1;
         m_cnt++;
         if (m_cnt == m_nr) begin
            done_n = 1'b1;
            m_busy = 1'b0;
         end
      end
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back(r);
      m_done = done_n;
   endtask

   // One clock: compare the current cycle's outputs, drive this cycle's inputs, advance the model.
   task automatic tick();
      row_t e;
      if (cyc > 0) begin
         e = (q.size() != 0) ? q[0] : '0;
         chk("o_valid",   RW'(bus.o_valid),   RW'(q.size() != 0));
         chk("o_data",    bus.o_data,         e);
         chk("fill",      RW'(bus.fill),      RW'(q.size()));
         chk("busy",      RW'(bus.busy),      RW'(m_busy));
         chk("tile_done", RW'(bus.tile_done), RW'(m_done));
         chk("skew_err",  RW'(bus.skew_err),  RW'(m_skew));
         chk("ovf_err",   RW'(bus.ovf_err),   RW'(m_ovf));
         if (bus.tile_done === 1'b1) done_seen++;
      end
      if (rand_rdy) rdy = 1'($urandom_range(0, 1));
      if (!sv.exists(cyc)) sv[cyc] = '0;
      if (!sd.exists(cyc)) sd[cyc] = rand_row();
      bus.i_valid  = sv[cyc];
      bus.i_data   = sd[cyc];
      bus.start    = st;
      bus.num_rows = nr;
      bus.o_ready  = rdy;
      rst          = rs;
      model_step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic reset_pulse();
      rs = 1'b1; tick();
      rs = 1'b0; tick();
   endtask

   task automatic basic_tile(input logic fixed);
      int t0, base;
      row_t rows [3];
      base = done_seen;
      rdy  = 1'b1; nr = 3; st = 1'b1;
      t0   = cyc + 2;
      for (int k = 0; k < 3; k++) begin
         rows[k] = fixed ? mk_row(100 * k) : rand_row();
         sched_row(t0 + k, rows[k], -1);
      end
      tick(); st = 1'b0;
      run_to(t0 + 3);
      chk("tile_valid_early", RW'(bus.o_valid), RW'(0));
      tick();
      chk("tile_valid_first", RW'(bus.o_valid), RW'(1));
      chk("tile_row0",        bus.o_data,       rows[0]);
      tick();
      chk("tile_row1",        bus.o_data,       rows[1]);
      chk("tile_busy_mid",    RW'(bus.busy),    RW'(1));
      tick();
      chk("tile_row2",        bus.o_data,       rows[2]);
      chk("tile_done_pulse",  RW'(bus.tile_done), RW'(1));
      chk("tile_busy_fall",   RW'(bus.busy),    RW'(0));
      repeat (4) tick();
      chk("tile_done_once",   RW'(done_seen - base), RW'(1));
      chk("tile_fill_empty",  RW'(bus.fill),    RW'(0));
   endtask

   initial begin
      int t0, base, s, n;
      cyc = 0; last_rst = 0; checks = 0; errors = 0; done_seen = 0;
      st = 1'b0; rs = 1'b1; rdy = 1'b0; rand_rdy = 1'b0; nr = '0;
      m_busy = 1'b0; m_done = 1'b0; m_skew = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_nr = 0;
      bus.i_valid = '0; bus.i_data = '0; bus.start = 1'b0; bus.num_rows = '0; bus.o_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      repeat (3) tick();
      rs = 1'b0;
      repeat (2) tick();
      chk("reset_fill",  RW'(bus.fill),    RW'(0));
      chk("reset_valid", RW'(bus.o_valid), RW'(0));

      // Three-row tile with recognisable data
      basic_tile(1'b1);

      // Consumer stalled: 20 rows into a 16-deep FIFO
      reset_pulse();
      base = done_seen; rdy = 1'b0; nr = 20; st = 1'b1; t0 = cyc + 2;
      for (int k = 0; k < 20; k++) sched_row(t0 + k, rand_row(), -1);
      tick(); st = 1'b0;
      run_to(t0 + 25);
      chk("ovf_fill_full", RW'(bus.fill),    RW'(DEPTH));
      chk("ovf_flag",      RW'(bus.ovf_err), RW'(1));
      chk("ovf_tile_done", RW'(done_seen - base), RW'(1));
      rdy = 1'b1;
      repeat (18) tick();
      chk("ovf_drained",   RW'(bus.fill),    RW'(0));

      // Full FIFO with a pop in the same cycle as a new row
      reset_pulse();
      rdy = 1'b0; nr = 17; st = 1'b1; t0 = cyc + 2;
      for (int k = 0; k < 17; k++) sched_row(t0 + k, rand_row(), -1);
      tick(); st = 1'b0;
      run_to(t0 + 19);
      chk("pp_fill_before", RW'(bus.fill), RW'(DEPTH));
      rdy = 1'b1;
      tick();
      chk("pp_fill_after",  RW'(bus.fill),    RW'(DEPTH));
      chk("pp_no_ovf",      RW'(bus.ovf_err), RW'(0));
      repeat (18) tick();

      // Column 2 one cycle late
      reset_pulse();
      base = done_seen; rdy = 1'b1; nr = 2; st = 1'b1; t0 = cyc + 2;
      sched_row(t0, rand_row(), 2);
      sched_row(t0 + 5, rand_row(), -1);
      tick(); st = 1'b0;
      run_to(t0 + 3);
      chk("skew_valid_early", RW'(bus.o_valid), RW'(0));
      tick();
      chk("skew_valid",  RW'(bus.o_valid),  RW'(1));
      chk("skew_flag",   RW'(bus.skew_err), RW'(1));
      run_to(t0 + 14);
      chk("skew_sticky", RW'(bus.skew_err), RW'(1));
      chk("skew_done",   RW'(done_seen - base), RW'(1));

      // Rows with no tile open
      reset_pulse();
      t0 = cyc + 2;
      for (int k = 0; k < 3; k++) sched_row(t0 + 2 * k, rand_row(), -1);
      repeat (12) tick();
      chk("idle_fill", RW'(bus.fill),    RW'(0));
      chk("idle_ovf",  RW'(bus.ovf_err), RW'(1));

      // Reset mid-tile with rows stored and in flight
      reset_pulse();
      rdy = 1'b0; nr = 10; st = 1'b1; t0 = cyc + 2;
      for (int k = 0; k < 6; k++) sched_row(t0 + k, rand_row(), -1);
      tick(); st = 1'b0;
      run_to(t0 + 8);
      chk("mid_fill5", RW'(bus.fill), RW'(5));
      rs = 1'b1; tick(); rs = 1'b0;
      chk("mid_rst_valid", RW'(bus.o_valid), RW'(0));
      chk("mid_rst_data",  bus.o_data,       '0);
      chk("mid_rst_fill",  RW'(bus.fill),    RW'(0));
      chk("mid_rst_busy",  RW'(bus.busy),    RW'(0));
      chk("mid_rst_ovf",   RW'(bus.ovf_err), RW'(0));
      repeat (4) tick();
      basic_tile(1'b0);
      chk("mid_after_ovf", RW'(bus.ovf_err), RW'(0));

      // Randomized tiles, gaps and consumer stalls
      rand_rdy = 1'b1;
      for (int it = 0; it < 10; it++) begin
         n  = $urandom_range(0, 12);
         nr = CNT_W'(n);
         st = 1'b1;
         s  = cyc + 1 + $urandom_range(0, 2);
         for (int k = 0; k < n; k++) begin
            sched_row(s, rand_row(), ($urandom_range(0, 15) == 0) ? 1 : -1);
            s = s + 2 + $urandom_range(0, 2);
         end
         tick(); st = 1'b0;
         run_to(s + N + 6);
      end
      rand_rdy = 1'b0; rdy = 1'b1;
      repeat (20) tick();
      chk("final_fill", RW'(bus.fill), RW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
